// File: rtl/phy_rx_deserializador_pkg.sv
// -----------------------------------------------------------------------------
// phy_rx_deserializador_pkg
// Shared constants, state encoding and helper functions for the receive-side
// serial-to-parallel stage. The COMMA value here must match the transmitter's
// idle filler character.
// -----------------------------------------------------------------------------
package phy_rx_deserializador_pkg;

    // Payload bits per character (the valid bit is carried separately).
    localparam int DATA_W      = 8;
    // Idle / alignment character.
    localparam logic [DATA_W-1:0] COMMA = 8'hBC;
    // Consecutive aligned commas required before the link is declared active.
    localparam int SYNC_COUNT  = 4;

    localparam int BIT_CNT_W   = $clog2(DATA_W);
    localparam int COMMA_CNT_W = $clog2(SYNC_COUNT + 1);

    // Alignment state machine encoding; 2'd3 is never entered legally.
    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_SYNC    = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_ILLEGAL = 2'd3
    } rx_state_e;

    // True when a character window equals the alignment character.
    function automatic logic f_is_comma(input logic [DATA_W-1:0] word);
        return (word == COMMA);
    endfunction

endpackage

// File: rtl/phy_rx_comma_det.sv
// -----------------------------------------------------------------------------
// phy_rx_comma_det
// Compares the incoming shift-register window against COMMA and keeps the
// registered bit counter that marks byte boundaries once alignment is locked.
//
// Ports:
//   i_clk         bit clock
//   i_rst_n       asynchronous active-low reset
//   i_shreg_next  shift-register contents including the bit sampled this edge
//   i_align       force the bit counter to 0 (byte boundary locked this edge)
//   i_count_en    advance the bit counter (aligned states); else hold at 0
//   o_comma       i_shreg_next equals COMMA
//   o_boundary    this edge samples the last bit of an aligned byte
// -----------------------------------------------------------------------------
module phy_rx_comma_det
    import phy_rx_deserializador_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_shreg_next,
    input  logic              i_align,
    input  logic              i_count_en,
    output logic              o_comma,
    output logic              o_boundary
);

    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_W - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_ONE  = BIT_CNT_W'(1);

    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic [BIT_CNT_W-1:0] w_bit_cnt_next;

    assign o_comma    = f_is_comma(i_shreg_next);
    assign o_boundary = (r_bit_cnt == BIT_LAST);

    // Bit counter next value: lock to 0 on alignment, count (with natural wrap) while aligned.
    always_comb begin
        w_bit_cnt_next = {BIT_CNT_W{1'b0}};
        if (i_align) begin
            w_bit_cnt_next = {BIT_CNT_W{1'b0}};
        end else if (i_count_en) begin
            w_bit_cnt_next = r_bit_cnt + BIT_ONE;
        end else begin
            w_bit_cnt_next = {BIT_CNT_W{1'b0}};
        end
    end

    // Bit counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit_cnt <= {BIT_CNT_W{1'b0}};
        end else begin
            r_bit_cnt <= w_bit_cnt_next;
        end
    end

endmodule

// File: rtl/phy_rx_deserializador.sv
// -----------------------------------------------------------------------------
// phy_rx_deserializador
// Receive-side serial-to-parallel stage. Hunts bit-by-bit for COMMA, confirms
// alignment with SYNC_COUNT consecutive aligned commas, then delivers one
// {valid,data} word per byte with a one-cycle strobe. Once active the link
// stays active until reset; there is no realignment.
//
// Ports:
//   clk16f        bit clock, one serial bit per rising edge
//   reset_L       asynchronous active-low reset
//   serial_in     serial data, MSB first
//   paralelo_out  {valid, data}; idle (comma) is reported as all zeros
//   strobe        one-cycle pulse when paralelo_out has been updated
//   active        link synchronized and delivering bytes
//   state_o       current alignment state (debug)
// -----------------------------------------------------------------------------
module phy_rx_deserializador
    import phy_rx_deserializador_pkg::*;
(
    input  logic              clk16f,
    input  logic              reset_L,
    input  logic              serial_in,
    output logic [DATA_W:0]   paralelo_out,
    output logic              strobe,
    output logic              active,
    output logic [1:0]        state_o
);

    localparam logic [COMMA_CNT_W-1:0] CNT_ZERO    = {COMMA_CNT_W{1'b0}};
    localparam logic [COMMA_CNT_W-1:0] CNT_ONE     = COMMA_CNT_W'(1);
    localparam logic [COMMA_CNT_W-1:0] SYNC_TARGET = COMMA_CNT_W'(SYNC_COUNT);

    logic [DATA_W-1:0]      r_shreg;
    logic [DATA_W-1:0]      w_shreg_next;
    rx_state_e              r_state;
    rx_state_e              w_state_next;
    logic [COMMA_CNT_W-1:0] r_comma_cnt;
    logic [COMMA_CNT_W-1:0] w_comma_cnt_next;
    logic [DATA_W:0]        r_par;
    logic [DATA_W:0]        w_par_next;
    logic                   r_strobe;
    logic                   w_strobe_next;
    logic                   r_active;
    logic                   w_active_next;
    logic                   w_comma;
    logic                   w_boundary;
    logic                   w_align;
    logic                   w_count_en;

    // The comparison sees the bit arriving on this edge, so a match locks
    // the boundary without waiting an extra cycle.
    assign w_shreg_next = {r_shreg[DATA_W-2:0], serial_in};
    assign w_align      = (r_state == ST_SEARCH) && w_comma;
    assign w_count_en   = (r_state != ST_SEARCH);

    phy_rx_comma_det u_comma_det (
        .i_clk        (clk16f),
        .i_rst_n      (reset_L),
        .i_shreg_next (w_shreg_next),
        .i_align      (w_align),
        .i_count_en   (w_count_en),
        .o_comma      (w_comma),
        .o_boundary   (w_boundary)
    );

    // Serial shift register, MSB first.
    always_ff @(posedge clk16f or negedge reset_L) begin
        if (!reset_L) begin
            r_shreg <= {DATA_W{1'b0}};
        end else begin
            r_shreg <= w_shreg_next;
        end
    end

    // FSM state and comma counter registers.
    always_ff @(posedge clk16f or negedge reset_L) begin
        if (!reset_L) begin
            r_state     <= ST_SEARCH;
            r_comma_cnt <= CNT_ZERO;
        end else begin
            r_state     <= w_state_next;
            r_comma_cnt <= w_comma_cnt_next;
        end
    end

    // Next-state logic: bit-granular hunt in SEARCH, byte-granular confirm in SYNC.
    always_comb begin
        w_state_next     = r_state;
        w_comma_cnt_next = r_comma_cnt;
        case (r_state)
            ST_SEARCH: begin
                if (w_comma) begin
                    w_comma_cnt_next = CNT_ONE;
                    if (SYNC_TARGET == CNT_ONE) begin
                        w_state_next = ST_ACTIVE;
                    end else begin
                        w_state_next = ST_SYNC;
                    end
                end else begin
                    w_comma_cnt_next = CNT_ZERO;
                    w_state_next     = ST_SEARCH;
                end
            end
            ST_SYNC: begin
                if (w_boundary) begin
                    if (w_comma) begin
                        w_comma_cnt_next = r_comma_cnt + CNT_ONE;
                        if ((r_comma_cnt + CNT_ONE) == SYNC_TARGET) begin
                            w_state_next = ST_ACTIVE;
                        end else begin
                            w_state_next = ST_SYNC;
                        end
                    end else begin
                        // One misaligned character drops the lock attempt.
                        w_comma_cnt_next = CNT_ZERO;
                        w_state_next     = ST_SEARCH;
                    end
                end else begin
                    w_state_next = ST_SYNC;
                end
            end
            ST_ACTIVE: begin
                w_state_next = ST_ACTIVE;
            end
            default: begin
                w_state_next     = ST_SEARCH;
                w_comma_cnt_next = CNT_ZERO;
            end
        endcase
    end

    // Output next values: deliver a word only on aligned boundaries in ACTIVE.
    always_comb begin
        w_par_next    = r_par;
        w_strobe_next = 1'b0;
        w_active_next = (w_state_next == ST_ACTIVE);
        case (r_state)
            ST_ACTIVE: begin
                if (w_boundary) begin
                    w_strobe_next = 1'b1;
                    if (w_comma) begin
                        w_par_next = {(DATA_W+1){1'b0}};
                    end else begin
                        w_par_next = {1'b1, w_shreg_next};
                    end
                end else begin
                    w_par_next    = r_par;
                    w_strobe_next = 1'b0;
                end
            end
            default: begin
                w_par_next    = r_par;
                w_strobe_next = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk16f or negedge reset_L) begin
        if (!reset_L) begin
            r_par    <= {(DATA_W+1){1'b0}};
            r_strobe <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_par    <= w_par_next;
            r_strobe <= w_strobe_next;
            r_active <= w_active_next;
        end
    end

    assign paralelo_out = r_par;
    assign strobe       = r_strobe;
    assign active       = r_active;
    assign state_o      = r_state;

endmodule

// File: tb/tb_phy_rx_deserializador.sv
// -----------------------------------------------------------------------------
// tb_phy_rx_deserializador
// Directed bench: expected words are queued as bytes are sent and compared
// whenever the DUT strobes; alignment timing and reset behaviour are checked
// at fixed points in the bit stream.
// -----------------------------------------------------------------------------
module tb_phy_rx_deserializador;

    logic       clk16f    = 1'b0;
    logic       reset_L   = 1'b1;
    logic       serial_in = 1'b0;
    logic [8:0] paralelo_out;
    logic       strobe;
    logic       active;
    logic [1:0] state_o;

    int         checks      = 0;
    int         errors      = 0;
    int         cyc         = 0;
    int         last_strobe = -1;
    int         strobe_cnt  = 0;
    logic [8:0] sb[$];
    logic [7:0] comma_v     = 8'hBC;

    phy_rx_deserializador dut (
        .clk16f       (clk16f),
        .reset_L      (reset_L),
        .serial_in    (serial_in),
        .paralelo_out (paralelo_out),
        .strobe       (strobe),
        .active       (active),
        .state_o      (state_o)
    );

    always #5 clk16f = ~clk16f;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one bit, let one edge pass, then score any strobe it produced.
    task automatic send_bit(input logic b);
        logic [8:0] exp_w;
        serial_in = b;
        @(posedge clk16f);
        #1;
        cyc++;
        if (strobe === 1'b1) begin
            strobe_cnt++;
            chk("strobe_expected", 16'(sb.size() != 0), 16'd1);
            if (sb.size() != 0) begin
                exp_w = sb.pop_front();
                chk("word", 16'(paralelo_out), 16'(exp_w));
            end
            if (last_strobe >= 0) begin
                chk("strobe_gap", 16'(cyc - last_strobe), 16'd8);
            end
            last_strobe = cyc;
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i]);
        end
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        serial_in = 1'b0;
        sb.delete();
        repeat (3) @(posedge clk16f);
        #1;
        chk("rst_par", 16'(paralelo_out), 16'h000);
        chk("rst_strobe", 16'(strobe), 16'd0);
        chk("rst_active", 16'(active), 16'd0);
        chk("rst_state", 16'(state_o), 16'd0);
        reset_L     = 1'b1;
        cyc         = 0;
        last_strobe = -1;
        strobe_cnt  = 0;
    endtask

    // n-1 full commas plus 7 bits must not be enough; the final bit must lock.
    task automatic sync_commas(input int n, input string tag);
        for (int k = 0; k < n - 1; k++) begin
            send_byte(comma_v);
        end
        for (int i = 7; i >= 1; i--) begin
            send_bit(comma_v[i]);
        end
        chk({tag, "_pre_active"}, 16'(active), 16'd0);
        chk({tag, "_pre_state"}, 16'(state_o), 16'd1);
        send_bit(comma_v[0]);
        chk({tag, "_active"}, 16'(active), 16'd1);
        chk({tag, "_state"}, 16'(state_o), 16'd2);
    endtask

    initial begin
        // 1: aligned commas from bit 0, active on cycle 32, no strobe yet.
        do_reset();
        sync_commas(4, "t1");
        chk("t1_cycle", 16'(cyc), 16'd32);
        chk("t1_no_strobe", 16'(strobe_cnt), 16'd0);

        // 2: lock found at bit offset 3 after garbage bits.
        do_reset();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        sync_commas(4, "t2");
        chk("t2_cycle", 16'(cyc), 16'd35);
        sb.push_back(9'h000);
        send_byte(8'hBC);
        sb.push_back(9'h1A5);
        send_byte(8'hA5);
        chk("t2_drained", 16'(sb.size()), 16'd0);
        chk("t2_strobes", 16'(strobe_cnt), 16'd2);

        // 3: a non-comma during SYNC restarts the hunt.
        do_reset();
        send_byte(comma_v);
        send_byte(comma_v);
        chk("t3_sync", 16'(state_o), 16'd1);
        send_byte(8'h3C);
        chk("t3_search", 16'(state_o), 16'd0);
        sync_commas(4, "t3");
        chk("t3_cycle", 16'(cyc), 16'd56);

        // 4: data patterns in ACTIVE, including a data comma reading as idle.
        sb.push_back(9'h1FF);
        send_byte(8'hFF);
        sb.push_back(9'h100);
        send_byte(8'h00);
        sb.push_back(9'h000);
        send_byte(8'hBC);
        sb.push_back(9'h181);
        send_byte(8'h81);
        chk("t4_drained", 16'(sb.size()), 16'd0);
        chk("t4_strobes", 16'(strobe_cnt), 16'd4);

        // 5: asynchronous reset mid-byte clears outputs before the next edge.
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        chk("t5_pre_par", 16'(paralelo_out), 16'h181);
        chk("t5_pre_active", 16'(active), 16'd1);
        #1;
        reset_L = 1'b0;
        #1;
        chk("t5_async_par", 16'(paralelo_out), 16'h000);
        chk("t5_async_strobe", 16'(strobe), 16'd0);
        chk("t5_async_active", 16'(active), 16'd0);
        chk("t5_async_state", 16'(state_o), 16'd0);
        do_reset();
        sync_commas(4, "t5");
        chk("t5_no_strobe", 16'(strobe_cnt), 16'd0);

        // 6: comma straddling a byte boundary in ACTIVE is ignored.
        sb.push_back(9'h10B);
        send_byte(8'h0B);
        sb.push_back(9'h1C0);
        send_byte(8'hC0);
        chk("t6_drained", 16'(sb.size()), 16'd0);
        chk("t6_strobes", 16'(strobe_cnt), 16'd2);
        chk("t6_state", 16'(state_o), 16'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
